univ_reg: RTL and testbench

UNIV_REG -- requirements
Module: univ_reg

---
 rtl/univ_reg.sv | 123 ++++++++++++
 tb/tb_univ_reg.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/univ_reg.sv
// Universal shift register: parallel load, single-bit shift/rotate, and
// multi-cycle shift-by-N sequenced by a small IDLE/RUN state machine.
module univ_reg #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             R,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in,
  input  logic             sin,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] out,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHL   = 3'b010,
    OP_SHR   = 3'b011,
    OP_ROL   = 3'b100,
    OP_ROR   = 3'b101,
    OP_SHL_N = 3'b110,
    OP_SHR_N = 3'b111
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic             dir_q, dir_d;      // 1 = shift right during RUN
  logic [WIDTH-1:0] out_q, out_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    out_d   = out_q;
    sout_d  = sout_q;
    done_d  = 1'b0;

    if (en) begin
      if (state_q == IDLE) begin
        case (op_t'(op))
          OP_LOAD: out_d = in;
          OP_SHL: begin
            out_d  = {out_q[WIDTH-2:0], sin};
            sout_d = out_q[WIDTH-1];
          end
          OP_SHR: begin
            out_d  = {sin, out_q[WIDTH-1:1]};
            sout_d = out_q[0];
          end
          OP_ROL: begin
            out_d  = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
            sout_d = out_q[WIDTH-1];
          end
          OP_ROR: begin
            out_d  = {out_q[0], out_q[WIDTH-1:1]};
            sout_d = out_q[0];
          end
          OP_SHL_N: begin
            state_d = RUN;
            count_d = amt;
            dir_d   = 1'b0;
          end
          OP_SHR_N: begin
            state_d = RUN;
            count_d = amt;
            dir_d   = 1'b1;
          end
          default: ;
        endcase
      end else if (count_q != '0) begin
        count_d = count_q - AMT_W'(1);
        if (dir_q) begin
          out_d  = {sin, out_q[WIDTH-1:1]};
          sout_d = out_q[0];
        end else begin
          out_d  = {out_q[WIDTH-2:0], sin};
          sout_d = out_q[WIDTH-1];
        end
      end else begin
        // Terminal RUN cycle spends no shift; it only retires the op.
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= IDLE;
      count_q <= '0;
      dir_q   <= 1'b0;
      out_q   <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign sout = sout_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_univ_reg.sv
// Bench for univ_reg: a 32-bit instance driven from a vector table and an
// 8-bit instance driven by a hand-written sequence, both through one scoreboard.
module tb_univ_reg;

  logic        clk = 1'b0;
  logic        r, en, sin;
  logic [2:0]  op;
  logic [31:0] din;
  logic [4:0]  amt;

  logic [31:0] out32;
  logic        sout32, busy32, done32;
  logic [7:0]  out8;
  logic        sout8, busy8, done8;

  always #5 clk = ~clk;

  univ_reg #(.WIDTH(32), .AMT_W(5)) dut32 (
    .clk(clk), .R(r), .en(en), .op(op), .in(din), .sin(sin), .amt(amt),
    .out(out32), .sout(sout32), .busy(busy32), .done(done32)
  );

  univ_reg #(.WIDTH(8), .AMT_W(4)) dut8 (
    .clk(clk), .R(r), .en(en), .op(op), .in(din[7:0]), .sin(sin), .amt(amt[3:0]),
    .out(out8), .sout(sout8), .busy(busy8), .done(done8)
  );

  typedef struct {
    string       name;
    bit          w8;
    logic        r, en;
    logic [2:0]  op;
    logic [31:0] din;
    logic        sin;
    logic [4:0]  amt;
    logic [31:0] eout;
    logic        esout, ebusy, edone;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(string name, bit w8, logic r_i, logic en_i, logic [2:0] op_i,
                              logic [31:0] din_i, logic sin_i, logic [4:0] amt_i,
                              logic [31:0] eout, logic esout, logic ebusy, logic edone);
    vec_t v;
    v.name = name; v.w8 = w8; v.r = r_i; v.en = en_i; v.op = op_i; v.din = din_i;
    v.sin = sin_i; v.amt = amt_i; v.eout = eout; v.esout = esout;
    v.ebusy = ebusy; v.edone = edone;
    return v;
  endfunction

  task automatic check(string name, string field, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
  endtask

  task automatic apply(vec_t v);
    vec_t e;
    @(negedge clk);
    r = v.r; en = v.en; op = v.op; din = v.din; sin = v.sin; amt = v.amt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.w8) begin
      check(e.name, "out",  {24'h0, out8}, e.eout);
      check(e.name, "sout", {31'h0, sout8}, {31'h0, e.esout});
      check(e.name, "busy", {31'h0, busy8}, {31'h0, e.ebusy});
      check(e.name, "done", {31'h0, done8}, {31'h0, e.edone});
      $display("vec %-10s w8  out=%h sout=%b busy=%b done=%b", e.name, out8, sout8, busy8, done8);
    end else begin
      check(e.name, "out",  out32, e.eout);
      check(e.name, "sout", {31'h0, sout32}, {31'h0, e.esout});
      check(e.name, "busy", {31'h0, busy32}, {31'h0, e.ebusy});
      check(e.name, "done", {31'h0, done32}, {31'h0, e.edone});
      $display("vec %-10s w32 out=%h sout=%b busy=%b done=%b", e.name, out32, sout32, busy32, done32);
    end
  endtask

  initial begin
    logic [7:0] e8;
    logic       es8;
    r = 1'b1; en = 1'b0; op = 3'b000; din = '0; sin = 1'b0; amt = '0;

    //            name        w8 r  en op    din           sin amt  eout          so bsy dn
    tbl.push_back(mk("reset",  0, 1, 1, 3'd1, 32'hFFFFFFFF, 1, 0, 32'h00000000, 0, 0, 0));
    tbl.push_back(mk("load_a5",0, 0, 1, 3'd1, 32'hA5A50001, 0, 0, 32'hA5A50001, 0, 0, 0));
    tbl.push_back(mk("ror",    0, 0, 1, 3'd5, 32'h0,        0, 0, 32'hD2D28000, 1, 0, 0));
    tbl.push_back(mk("rol",    0, 0, 1, 3'd4, 32'h0,        0, 0, 32'hA5A50001, 1, 0, 0));
    tbl.push_back(mk("load_80",0, 0, 1, 3'd1, 32'h80000000, 0, 0, 32'h80000000, 1, 0, 0));
    tbl.push_back(mk("shl",    0, 0, 1, 3'd2, 32'h0,        1, 0, 32'h00000001, 1, 0, 0));
    tbl.push_back(mk("shr",    0, 0, 1, 3'd3, 32'h0,        0, 0, 32'h00000000, 1, 0, 0));
    tbl.push_back(mk("hold",   0, 0, 1, 3'd0, 32'hFFFFFFFF, 1, 0, 32'h00000000, 1, 0, 0));
    tbl.push_back(mk("en0",    0, 0, 0, 3'd1, 32'hFFFFFFFF, 1, 0, 32'h00000000, 1, 0, 0));
    tbl.push_back(mk("load_f0",0, 0, 1, 3'd1, 32'h000000F0, 0, 0, 32'h000000F0, 1, 0, 0));
    tbl.push_back(mk("shrn4",  0, 0, 1, 3'd7, 32'h0,        0, 4, 32'h000000F0, 1, 1, 0));
    tbl.push_back(mk("shrn_s1",0, 0, 1, 3'd1, 32'hFFFFFFFF, 0, 0, 32'h00000078, 0, 1, 0));
    tbl.push_back(mk("shrn_s2",0, 0, 1, 3'd1, 32'hFFFFFFFF, 0, 0, 32'h0000003C, 0, 1, 0));
    tbl.push_back(mk("shrn_s3",0, 0, 1, 3'd1, 32'hFFFFFFFF, 0, 0, 32'h0000001E, 0, 1, 0));
    tbl.push_back(mk("shrn_s4",0, 0, 1, 3'd1, 32'hFFFFFFFF, 0, 0, 32'h0000000F, 0, 1, 0));
    tbl.push_back(mk("shrn_end",0,0, 1, 3'd1, 32'hFFFFFFFF, 0, 0, 32'h0000000F, 0, 0, 1));
    tbl.push_back(mk("post",   0, 0, 1, 3'd0, 32'h0,        0, 0, 32'h0000000F, 0, 0, 0));
    tbl.push_back(mk("shln0",  0, 0, 1, 3'd6, 32'h0,        1, 0, 32'h0000000F, 0, 1, 0));
    tbl.push_back(mk("shln0_e",0, 0, 1, 3'd0, 32'h0,        1, 0, 32'h0000000F, 0, 0, 1));
    tbl.push_back(mk("shln3",  0, 0, 1, 3'd6, 32'h0,        1, 3, 32'h0000000F, 0, 1, 0));
    tbl.push_back(mk("pause1", 0, 0, 0, 3'd0, 32'h0,        1, 0, 32'h0000000F, 0, 1, 0));
    tbl.push_back(mk("shln3_1",0, 0, 1, 3'd0, 32'h0,        1, 0, 32'h0000001F, 0, 1, 0));
    tbl.push_back(mk("pause2", 0, 0, 0, 3'd1, 32'h0,        0, 0, 32'h0000001F, 0, 1, 0));
    tbl.push_back(mk("shln3_2",0, 0, 1, 3'd0, 32'h0,        0, 0, 32'h0000003E, 0, 1, 0));
    tbl.push_back(mk("shln3_3",0, 0, 1, 3'd0, 32'h0,        1, 0, 32'h0000007D, 0, 1, 0));
    tbl.push_back(mk("shln3_e",0, 0, 1, 3'd1, 32'h12345678, 0, 0, 32'h0000007D, 0, 0, 1));
    tbl.push_back(mk("ld_indone",0,0,1, 3'd1, 32'h12345678, 0, 0, 32'h12345678, 0, 0, 0));
    tbl.push_back(mk("load_1", 0, 0, 1, 3'd1, 32'h00000001, 0, 0, 32'h00000001, 0, 0, 0));
    tbl.push_back(mk("shln8",  0, 0, 1, 3'd6, 32'h0,        0, 8, 32'h00000001, 0, 1, 0));
    tbl.push_back(mk("shln8_1",0, 0, 1, 3'd0, 32'h0,        0, 0, 32'h00000002, 0, 1, 0));
    tbl.push_back(mk("shln8_2",0, 0, 1, 3'd0, 32'h0,        0, 0, 32'h00000004, 0, 1, 0));
    tbl.push_back(mk("shln8_3",0, 0, 1, 3'd0, 32'h0,        0, 0, 32'h00000008, 0, 1, 0));
    tbl.push_back(mk("abort",  0, 1, 1, 3'd0, 32'h0,        0, 0, 32'h00000000, 0, 0, 0));
    tbl.push_back(mk("no_done",0, 0, 1, 3'd0, 32'h0,        0, 0, 32'h00000000, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // 8-bit instance: rotate wrap, then a shift count larger than WIDTH.
    apply(mk("w8_reset", 1, 1, 0, 3'd0, 32'h0,  0, 0,  32'h00, 0, 0, 0));
    apply(mk("w8_load",  1, 0, 1, 3'd1, 32'h81, 0, 0,  32'h81, 0, 0, 0));
    apply(mk("w8_rol",   1, 0, 1, 3'd4, 32'h0,  0, 0,  32'h03, 1, 0, 0));
    apply(mk("w8_shln10",1, 0, 1, 3'd6, 32'h0,  1, 10, 32'h03, 1, 1, 0));
    e8 = 8'h03;
    for (int k = 0; k < 10; k++) begin
      es8 = e8[7];
      e8  = {e8[6:0], 1'b1};
      apply(mk($sformatf("w8_s%0d", k + 1), 1, 0, 1, 3'd0, 32'h0, 1, 0, {24'h0, e8}, es8, 1, 0));
    end
    apply(mk("w8_end",   1, 0, 1, 3'd0, 32'h0,  1, 0,  32'hFF, 1, 0, 1));
    apply(mk("w8_post",  1, 0, 1, 3'd0, 32'h0,  1, 0,  32'hFF, 1, 0, 0));

    if (sb.size() != 0) check("scoreboard", "leftover", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
